// File: rtl/cs_frame_buffer_if.sv
// Port bundle for cs_frame_buffer: sample strobe in, valid/ready sample out,
// plus occupancy and sticky overflow status.
interface cs_frame_buffer_if #(
    parameter int AW    = 3,
    parameter int IDX_W = 4
);
    // Input side has no backpressure: x_i is taken whenever srdyi_i=1 (or dropped when full).
    // Output side is valid/ready: a word transfers on a rising edge where srdyo_o & drdyi_i;
    // while srdyo_o=1 and drdyi_i=0 the head (z_o, idx_o, last_o) holds.
    logic [31:0]      x_i;
    logic             srdyi_i;
    logic             drdyi_i;
    logic             clr_ovf_i;
    logic [31:0]      z_o;
    logic             srdyo_o;
    logic [IDX_W-1:0] idx_o;
    logic             last_o;
    logic [AW:0]      count_o;
    logic             overflow_o;

    modport master (
        output x_i, srdyi_i, drdyi_i, clr_ovf_i,
        input  z_o, srdyo_o, idx_o, last_o, count_o, overflow_o
    );

    modport slave (
        input  x_i, srdyi_i, drdyi_i, clr_ovf_i,
        output z_o, srdyo_o, idx_o, last_o, count_o, overflow_o
    );
endinterface

// File: rtl/cs_frame_buffer.sv
// First-word-fall-through sample FIFO between centre/scale and the classifier,
// tagging each delivered sample with its position in a fixed-length frame.
module cs_frame_buffer #(
    parameter int AW        = 3,
    parameter int FRAME_LEN = 16,
    parameter int IDX_W     = 4
) (
    input logic             clk,
    input logic             GlobalReset,
    cs_frame_buffer_if.slave bus
);
    localparam int               DEPTH    = 1 << AW;
    localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [AW:0]      count, count_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             overflow, overflow_nxt;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = ~empty & bus.drdyi_i;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign push  = bus.srdyi_i & (~full | pop);
    assign drop  = bus.srdyi_i & full & ~pop;

    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        idx_nxt      = idx;
        overflow_nxt = overflow;

        if (push) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end

        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
            idx_nxt    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end

        case ({push, pop})
            2'b10:   count_nxt = count + (AW + 1)'(1);
            2'b01:   count_nxt = count - (AW + 1)'(1);
            default: count_nxt = count;
        endcase

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            overflow_nxt = 1'b1;
        end else if (bus.clr_ovf_i) begin
            overflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            idx      <= idx_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Storage is never reset; an empty FIFO masks it on z_o.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.x_i;
        end
    end

    assign bus.srdyo_o    = ~empty;
    assign bus.z_o        = empty ? 32'h0 : mem[rd_ptr];
    assign bus.idx_o      = idx;
    assign bus.last_o     = ~empty & (idx == LAST_IDX);
    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;
endmodule

// File: tb/tb_cs_frame_buffer.sv
// Bench for cs_frame_buffer: directed scenarios plus random traffic, scored
// against a queue-level model of the buffer.
module tb_cs_frame_buffer;
  localparam int AW = 3;
  localparam int IDX_W = 4;
  localparam int FRAME_LEN = 16;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic GlobalReset;
  int tests = 0;
  int errors = 0;

  cs_frame_buffer_if #(.AW(AW), .IDX_W(IDX_W)) bus ();

  cs_frame_buffer #(.AW(AW), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .GlobalReset(GlobalReset),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: accepted samples waiting for delivery, plus counters
  logic [31:0] exp_q[$];
  int m_cnt = 0;
  int m_deliv = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk or negedge GlobalReset) begin
    bit m_pop;
    bit m_push;
    if (!GlobalReset) begin
      exp_q.delete();
      m_cnt = 0;
      m_deliv = 0;
      m_ovf = 1'b0;
    end else begin
      m_pop = (m_cnt != 0) && bus.drdyi_i;
      m_push = bus.srdyi_i && ((m_cnt < DEPTH) || m_pop);
      if (m_push) exp_q.push_back(bus.x_i);
      if (m_pop) m_deliv++;
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      if (bus.srdyi_i && !m_push) m_ovf = 1'b1;
      else if (bus.clr_ovf_i) m_ovf = 1'b0;
    end
  end

  // monitor: compares every cycle away from the active edge
  always @(negedge clk) begin
    if (GlobalReset) begin
      check("srdyo", bus.srdyo_o, m_cnt != 0);
      check("count", bus.count_o, m_cnt);
      check("overflow", bus.overflow_o, m_ovf);
      check("idx", bus.idx_o, m_deliv % FRAME_LEN);
      if (bus.srdyo_o) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL head_unexpected actual=%0h required=none at %0t", bus.z_o, $time);
        end else begin
          check("z_head", bus.z_o, exp_q[0]);
          check("last", bus.last_o, (m_deliv % FRAME_LEN) == FRAME_LEN - 1);
          if (bus.drdyi_i) void'(exp_q.pop_front());
        end
      end else begin
        check("z_empty", bus.z_o, 32'h0);
        check("last_empty", bus.last_o, 1'b0);
      end
    end
  end

  // driver tasks
  task automatic drive(input bit s, input logic [31:0] x, input bit d, input bit c);
    bus.srdyi_i = s;
    bus.x_i = x;
    bus.drdyi_i = d;
    bus.clr_ovf_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.srdyi_i = 1'b0;
    bus.x_i = '0;
    bus.drdyi_i = 1'b0;
    bus.clr_ovf_i = 1'b0;
    GlobalReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    GlobalReset = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_srdyo"}, bus.srdyo_o, 1'b0);
    check({tag, "_z"}, bus.z_o, 32'h0);
    check({tag, "_count"}, bus.count_o, 0);
    check({tag, "_idx"}, bus.idx_o, 0);
    check({tag, "_last"}, bus.last_o, 1'b0);
    check({tag, "_ovf"}, bus.overflow_o, 1'b0);
  endtask

  initial begin
    int last_cnt;
    apply_reset();
    check_idle("reset");

    // single sample
    drive(1, 32'h3F80_0000, 1, 0);
    check("single_srdyo", bus.srdyo_o, 1'b1);
    check("single_z", bus.z_o, 32'h3F80_0000);
    check("single_idx", bus.idx_o, 0);
    check("single_count", bus.count_o, 1);
    drive(0, 0, 1, 0);
    check("single_gone", bus.srdyo_o, 1'b0);
    check("single_zero", bus.z_o, 32'h0);
    check("single_idx1", bus.idx_o, 1);

    // fill past full, then drain
    apply_reset();
    for (int i = 1; i <= 9; i++) drive(1, i, 0, 0);
    check("fill_count", bus.count_o, 8);
    check("fill_ovf", bus.overflow_o, 1'b1);
    check("fill_head", bus.z_o, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0);
    check("drain_count", bus.count_o, 0);

    // full with simultaneous push and pop
    apply_reset();
    for (int i = 1; i <= 8; i++) drive(1, i, 0, 0);
    drive(1, 9, 1, 0);
    check("fullpp_count", bus.count_o, 8);
    check("fullpp_ovf", bus.overflow_o, 1'b0);
    check("fullpp_head", bus.z_o, 2);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0);
    check("fullpp_empty", bus.count_o, 0);

    // frame wrap
    apply_reset();
    last_cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      drive(i <= 20, 32'h100 + i, 1, 0);
      if (bus.srdyo_o && bus.last_o) last_cnt++;
    end
    check("wrap_last_cnt", last_cnt, 1);
    check("wrap_idx", bus.idx_o, 4);

    // overflow clear priority
    apply_reset();
    for (int i = 1; i <= 8; i++) drive(1, i, 0, 0);
    drive(1, 99, 0, 1);
    check("ovf_clr_prio", bus.overflow_o, 1'b1);
    drive(0, 0, 0, 1);
    check("ovf_clr", bus.overflow_o, 1'b0);

    // async reset mid-frame
    apply_reset();
    for (int i = 1; i <= 7; i++) drive(1, i, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) drive(1, 32'h200 + i, 0, 0);
    check("mid_count", bus.count_o, 5);
    check("mid_idx", bus.idx_o, 7);
    @(negedge clk);
    #1;
    GlobalReset = 1'b0;
    #1;
    check_idle("async");
    @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    drive(1, 32'hCAFE_0001, 0, 0);
    check("post_rst_z", bus.z_o, 32'hCAFE_0001);
    check("post_rst_idx", bus.idx_o, 0);

    // random traffic; one async reset in the middle
    for (int i = 0; i < 600; i++) begin
      int thr;
      thr = (i % 200 < 100) ? 3 : 8;
      if (i == 300) begin
        @(negedge clk);
        #2;
        GlobalReset = 1'b0;
        #1;
        check_idle("rand_async");
        @(posedge clk);
        #1;
        GlobalReset = 1'b1;
      end
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < thr,
            $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 1, 1);
    check("final_count", bus.count_o, 0);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
